// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches from a combinational instruction memory
// and hands words to decode through a valid/ready IF/ID register.
// Optional performance counters are built when IF_FETCH_PERF_CNT_EN is defined.
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned IMEM_BYTES = 56,
   parameter logic [31:0] NOP_INST   = 32'h00000013
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] inst_address,
   input  logic [31:0] instruction,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [63:0] id_pc,
   output logic [31:0] id_instruction,
   input  logic        redirect,
   input  logic [63:0] redirect_target,
   output logic        halted,
`ifdef IF_FETCH_PERF_CNT_EN
   output logic [31:0] fetch_count,
   output logic [31:0] stall_count,
`endif
   output logic        misaligned
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_e;

   localparam logic [63:0] IMEM_LIMIT = 64'(IMEM_BYTES);
   localparam logic        RESET_FITS = (RESET_PC + 64'd4) <= IMEM_LIMIT;

   state_e      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        id_valid_q, id_valid_d;
   logic [63:0] id_pc_q, id_pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic        misaligned_q, misaligned_d;

   logic        pc_in_range;
   logic        advance;
   logic        redirect_taken;
   logic        fetch_en;

   // A fetch is legal only while the whole word lies inside the memory.
   assign pc_in_range    = (pc_q + 64'd4) <= IMEM_LIMIT;
   assign advance        = (state_q == RUN) && (!id_valid_q || id_ready) && pc_in_range;
   assign redirect_taken = redirect && (state_q != IDLE);
   assign fetch_en       = advance && !redirect_taken;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      id_valid_d   = id_valid_q;
      id_pc_d      = id_pc_q;
      id_inst_d    = id_inst_q;
      misaligned_d = misaligned_q;

      // A redirect flushes IF/ID even while decode is stalling.
      if (redirect_taken) begin
         id_valid_d = 1'b0;
         id_inst_d  = NOP_INST;
         if (redirect_target[1:0] == 2'b00) begin
            pc_d    = redirect_target;
            state_d = RUN;
         end else begin
            misaligned_d = 1'b1;
            state_d      = HALT;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = RESET_FITS ? RUN : HALT;
            end
            RUN: begin
               if (fetch_en) begin
                  id_inst_d  = instruction;
                  id_pc_d    = pc_q;
                  id_valid_d = 1'b1;
                  pc_d       = pc_q + 64'd4;
               end else if (id_valid_q && id_ready) begin
                  id_valid_d = 1'b0;
                  id_inst_d  = NOP_INST;
               end
               if (!pc_in_range) begin
                  state_d = HALT;
               end
            end
            HALT: begin
               // The last fetched entry drains to decode before fetch goes quiet.
               if (id_valid_q && id_ready) begin
                  id_valid_d = 1'b0;
                  id_inst_d  = NOP_INST;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         id_valid_q   <= 1'b0;
         id_pc_q      <= 64'h0;
         id_inst_q    <= NOP_INST;
         misaligned_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         id_valid_q   <= id_valid_d;
         id_pc_q      <= id_pc_d;
         id_inst_q    <= id_inst_d;
         misaligned_q <= misaligned_d;
      end
   end

   assign inst_address   = pc_q;
   assign id_valid       = id_valid_q;
   assign id_pc          = id_pc_q;
   assign id_instruction = id_inst_q;
   assign halted         = (state_q == HALT);
   assign misaligned     = misaligned_q;

`ifdef IF_FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;

   // Both counters saturate rather than wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (fetch_en && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         end
         if (id_valid_q && !id_ready && !redirect && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Testbench for if_fetch_stage: directed scenarios plus a randomized run checked
// against an in-order delivery scoreboard of the instruction stream.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        reset;
   logic [63:0] inst_address;
   logic [31:0] instruction;
   logic        id_valid;
   logic        id_ready;
   logic [63:0] id_pc;
   logic [31:0] id_instruction;
   logic        redirect;
   logic [63:0] redirect_target;
   logic        halted;
   logic        misaligned;
`ifdef IF_FETCH_PERF_CNT_EN
   logic [31:0] fetchCount;
   logic [31:0] stallCount;
`endif

   logic [31:0] imem [0:15];
   int checks;
   int failures;

   if_fetch_stage dut (
      .clk(clk),
      .reset(reset),
      .inst_address(inst_address),
      .instruction(instruction),
      .id_valid(id_valid),
      .id_ready(id_ready),
      .id_pc(id_pc),
      .id_instruction(id_instruction),
      .redirect(redirect),
      .redirect_target(redirect_target),
      .halted(halted),
`ifdef IF_FETCH_PERF_CNT_EN
      .fetch_count(fetchCount),
      .stall_count(stallCount),
`endif
      .misaligned(misaligned)
   );

   // Reference memory: 56 bytes of words, zero outside.
   function automatic logic [31:0] memWord(input logic [63:0] a);
      if ((a + 64'd4) <= 64'd56) return imem[a[5:2]];
      return 32'h0;
   endfunction

   always_comb instruction = memWord(inst_address);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Reset then run n cycles; id_pc = 4*(n-2) is on display once n >= 2.
   task automatic startRun(input int n);
      @(negedge clk);
      reset = 1'b1;
      redirect = 1'b0;
      redirect_target = 64'h0;
      id_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      redirect = 1'b0;
      redirect_target = 64'h0;
      id_ready = 1'b0;
      #2;
      checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", id_valid); end
      checks++; if (id_pc !== 64'h0) begin failures++; $display("[TB] FAIL reset_idpc: got %h expected 0", id_pc); end
      checks++; if (id_instruction !== NOP) begin failures++; $display("[TB] FAIL reset_inst: got %h expected %h", id_instruction, NOP); end
      checks++; if (inst_address !== 64'h0) begin failures++; $display("[TB] FAIL reset_addr: got %h expected 0", inst_address); end
      checks++; if (halted !== 1'b0 || misaligned !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags: halted=%b misaligned=%b expected 0 0", halted, misaligned); end
   endtask

   task automatic test_release();
      startRun(1);
      checks++; if (id_valid !== 1'b0 || inst_address !== 64'h0) begin failures++; $display("[TB] FAIL idle_cycle: valid=%b addr=%h expected 0 0", id_valid, inst_address); end
      cycle();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instruction !== 32'hB3027300) begin failures++; $display("[TB] FAIL first_fetch: valid=%b pc=%h inst=%h expected 1 0 b3027300", id_valid, id_pc, id_instruction); end
      cycle();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h4 || id_instruction !== 32'h00500093) begin failures++; $display("[TB] FAIL second_fetch: valid=%b pc=%h inst=%h expected 1 4 00500093", id_valid, id_pc, id_instruction); end
      cycle();
      checks++; if (id_pc !== 64'h8 || id_instruction !== imem[2]) begin failures++; $display("[TB] FAIL third_fetch: pc=%h inst=%h expected 8 %h", id_pc, id_instruction, imem[2]); end
   endtask

   task automatic test_backpressure();
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8 || id_instruction !== imem[2] || inst_address !== 64'hC) begin
            failures++; $display("[TB] FAIL stall_hold: valid=%b pc=%h inst=%h addr=%h expected 1 8 %h c", id_valid, id_pc, id_instruction, inst_address, imem[2]);
         end
      end
`ifdef IF_FETCH_PERF_CNT_EN
      checks++; if (stallCount !== 32'd3 || fetchCount !== 32'd3) begin failures++; $display("[TB] FAIL perf_counts: stall=%0d fetch=%0d expected 3 3", stallCount, fetchCount); end
`endif
      id_ready = 1'b1;
      cycle();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'hC || id_instruction !== imem[3]) begin failures++; $display("[TB] FAIL stall_release: pc=%h inst=%h expected c %h", id_pc, id_instruction, imem[3]); end
      cycle();
      checks++; if (id_pc !== 64'h10 || id_instruction !== imem[4]) begin failures++; $display("[TB] FAIL after_release: pc=%h inst=%h expected 10 %h", id_pc, id_instruction, imem[4]); end
   endtask

   task automatic test_redirect_stalled();
      startRun(4);
      id_ready = 1'b0;
      cycle();
      checks++; if (id_pc !== 64'h8 || id_valid !== 1'b1) begin failures++; $display("[TB] FAIL redir_setup: pc=%h valid=%b expected 8 1", id_pc, id_valid); end
      redirect = 1'b1;
      redirect_target = 64'h10;
      cycle();
      checks++; if (id_valid !== 1'b0 || id_instruction !== NOP || inst_address !== 64'h10) begin
         failures++; $display("[TB] FAIL redir_flush: valid=%b inst=%h addr=%h expected 0 %h 10", id_valid, id_instruction, inst_address, NOP);
      end
      redirect = 1'b0;
      id_ready = 1'b1;
      cycle();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h10 || id_instruction !== imem[4]) begin failures++; $display("[TB] FAIL redir_refill: pc=%h inst=%h expected 10 %h", id_pc, id_instruction, imem[4]); end
   endtask

   task automatic test_end_of_memory();
      startRun(15);
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h34 || id_instruction !== imem[13]) begin failures++; $display("[TB] FAIL last_word: pc=%h inst=%h expected 34 %h", id_pc, id_instruction, imem[13]); end
      cycle();
      checks++; if (halted !== 1'b1 || id_valid !== 1'b0 || inst_address !== 64'h38 || id_instruction !== NOP) begin
         failures++; $display("[TB] FAIL eom_halt: halted=%b valid=%b addr=%h inst=%h expected 1 0 38 %h", halted, id_valid, inst_address, id_instruction, NOP);
      end
      cycle();
      checks++; if (halted !== 1'b1 || inst_address !== 64'h38) begin failures++; $display("[TB] FAIL eom_stay: halted=%b addr=%h expected 1 38", halted, inst_address); end
      redirect = 1'b1;
      redirect_target = 64'h0;
      cycle();
      checks++; if (halted !== 1'b0 || inst_address !== 64'h0) begin failures++; $display("[TB] FAIL eom_resume: halted=%b addr=%h expected 0 0", halted, inst_address); end
      redirect = 1'b0;
      cycle();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_instruction !== imem[0]) begin failures++; $display("[TB] FAIL eom_refetch: pc=%h inst=%h expected 0 %h", id_pc, id_instruction, imem[0]); end
   endtask

   task automatic test_misaligned();
      startRun(3);
      redirect = 1'b1;
      redirect_target = 64'h6;
      cycle();
      checks++; if (misaligned !== 1'b1 || halted !== 1'b1 || inst_address !== 64'h8 || id_valid !== 1'b0) begin
         failures++; $display("[TB] FAIL misalign_halt: mis=%b halted=%b addr=%h valid=%b expected 1 1 8 0", misaligned, halted, inst_address, id_valid);
      end
      redirect_target = 64'h8;
      cycle();
      checks++; if (misaligned !== 1'b1 || halted !== 1'b0 || inst_address !== 64'h8) begin failures++; $display("[TB] FAIL misalign_sticky: mis=%b halted=%b addr=%h expected 1 0 8", misaligned, halted, inst_address); end
      redirect = 1'b0;
      cycle();
      checks++; if (id_valid !== 1'b1 || id_pc !== 64'h8 || misaligned !== 1'b1) begin failures++; $display("[TB] FAIL misalign_resume: valid=%b pc=%h mis=%b expected 1 8 1", id_valid, id_pc, misaligned); end
   endtask

   task automatic test_reset_midstream();
      startRun(5);
      redirect = 1'b1;
      redirect_target = 64'h2;
      cycle();
      redirect_target = 64'h0;
      cycle();
      redirect = 1'b0;
      cycle();
      checks++; if (id_valid !== 1'b1 || misaligned !== 1'b1) begin failures++; $display("[TB] FAIL mid_setup: valid=%b mis=%b expected 1 1", id_valid, misaligned); end
      reset = 1'b1;
      #1;
      checks++; if (id_valid !== 1'b0 || id_pc !== 64'h0 || id_instruction !== NOP || inst_address !== 64'h0 || halted !== 1'b0 || misaligned !== 1'b0) begin
         failures++; $display("[TB] FAIL mid_reset: valid=%b pc=%h inst=%h addr=%h halted=%b mis=%b expected 0 0 %h 0 0 0", id_valid, id_pc, id_instruction, inst_address, halted, misaligned, NOP);
      end
`ifdef IF_FETCH_PERF_CNT_EN
      checks++; if (fetchCount !== 32'd0 || stallCount !== 32'd0) begin failures++; $display("[TB] FAIL mid_reset_perf: fetch=%0d stall=%0d expected 0 0", fetchCount, stallCount); end
`endif
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Random readiness and redirects; every visible entry must be the next word in program order.
   task automatic test_random();
      logic [63:0] expPc;
      logic        expMis;
      logic        holdPending;
      int          accepted;
      int          k;
      startRun(1);
      expPc = 64'h0;
      expMis = 1'b0;
      holdPending = 1'b0;
      accepted = 0;
      for (int i = 0; i < 600; i++) begin
         checks++; if (misaligned !== expMis) begin failures++; $display("[TB] FAIL rand_mis[%0d]: got %b expected %b", i, misaligned, expMis); end
         if (id_valid === 1'b1) begin
            checks++; if (id_pc !== expPc || id_instruction !== memWord(expPc)) begin
               failures++; $display("[TB] FAIL rand_order[%0d]: pc=%h inst=%h expected %h %h", i, id_pc, id_instruction, expPc, memWord(expPc));
            end
         end else begin
            checks++; if (id_instruction !== NOP) begin failures++; $display("[TB] FAIL rand_nop[%0d]: got %h expected %h", i, id_instruction, NOP); end
         end
         if ((expPc + 64'd4) > 64'd56) begin
            checks++; if (id_valid !== 1'b0) begin failures++; $display("[TB] FAIL rand_bound[%0d]: valid=%b expected 0 for pc %h", i, id_valid, expPc); end
         end
         if (holdPending) begin
            checks++; if (id_valid !== 1'b1) begin failures++; $display("[TB] FAIL rand_stall[%0d]: valid=%b expected 1", i, id_valid); end
         end
         id_ready = ($urandom_range(0, 9) < 7);
         redirect = ($urandom_range(0, 19) == 0);
         k = int'($urandom_range(0, 16));
         redirect_target = 64'(4 * k);
         if ($urandom_range(0, 7) == 0) redirect_target = redirect_target + 64'($urandom_range(1, 3));
         if (redirect) begin
            if (redirect_target[1:0] == 2'b00) expPc = redirect_target;
            else expMis = 1'b1;
            holdPending = 1'b0;
         end else if (id_valid === 1'b1 && id_ready) begin
            expPc = expPc + 64'd4;
            accepted++;
            holdPending = 1'b0;
         end else begin
            holdPending = (id_valid === 1'b1);
         end
         cycle();
      end
      redirect = 1'b0;
      checks++; if (accepted < 20) begin failures++; $display("[TB] FAIL rand_progress: accepted %0d expected at least 20", accepted); end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      for (int i = 0; i < 16; i++) imem[i] = $urandom;
      imem[0] = 32'hB3027300;
      imem[1] = 32'h00500093;
      test_reset();
      test_release();
      test_backpressure();
      test_redirect_stalled();
      test_end_of_memory();
      test_misaligned();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
